// File: rtl/multi_sprite_line_engine_pkg.sv
// Shared types and helpers for the multi-sprite scanline renderer.
// Pure definitions: no latency, no flow control.
package multi_sprite_line_engine_pkg;

    localparam int MAX_SPRITES = 8;

    typedef logic [MAX_SPRITES-1:0] slot_vec_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHECK,
        ST_SETUP,
        ST_FETCH
    } fetch_state_t;

    function automatic logic [2:0] lowest_set(input slot_vec_t v);
        lowest_set = 3'd0;
        for (int i = MAX_SPRITES - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = 3'(i);
        end
    endfunction

    function automatic logic multi_hot(input slot_vec_t v);
        return (v & (v - slot_vec_t'(1))) != '0;
    endfunction

endpackage

// File: rtl/multi_sprite_line_engine_slot.sv
// One sprite slot: line buffer, latched x/hmir, arm-and-count draw logic.
// Opaque output is combinational from hpos; no backpressure, draws one pixel per clk.
module sprite_line_slot #(
    parameter int SPR_W  = 16,
    parameter int BYTE_W = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [8:0]        hpos,
    input  logic              kill,
    input  logic              load,
    input  logic [7:0]        x_in,
    input  logic              hmir_in,
    input  logic              wr_en,
    input  logic [BYTE_W-1:0] wr_byte,
    input  logic [7:0]        wr_dat,
    input  logic              set_active,
    input  logic              clr_active,
    output logic              opaque
);

    localparam int CNT_W = $clog2(SPR_W);

    logic [SPR_W-1:0] line_buf;
    logic [7:0]       x_q;
    logic             hmir_q;
    logic             active_q;
    logic             drawing_q;
    logic [CNT_W-1:0] cnt_q;
    logic             arm;
    logic [CNT_W-1:0] cnt_cur;
    logic [CNT_W-1:0] pix;

    // The arming cycle itself shows pixel 0, so the counter starts at 1 after it.
    assign arm     = active_q && !drawing_q && (hpos == {1'b0, x_q});
    assign cnt_cur = drawing_q ? cnt_q : '0;
    assign pix     = hmir_q ? (CNT_W'(SPR_W - 1) - cnt_cur) : cnt_cur;
    assign opaque  = (arm || drawing_q) && line_buf[pix];

    always_ff @(posedge clk) begin
        if (!reset) begin
            line_buf  <= '0;
            x_q       <= '0;
            hmir_q    <= 1'b0;
            active_q  <= 1'b0;
            drawing_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            if (wr_en) line_buf[{wr_byte, 3'b000} +: 8] <= wr_dat;
            if (load) begin
                x_q    <= x_in;
                hmir_q <= hmir_in;
            end
            if (kill || clr_active) begin
                active_q  <= 1'b0;
                drawing_q <= 1'b0;
            end else begin
                if (set_active) active_q <= 1'b1;
                if (arm) begin
                    drawing_q <= 1'b1;
                    cnt_q     <= CNT_W'(1);
                end else if (drawing_q) begin
                    if (cnt_q == CNT_W'(SPR_W - 1)) begin
                        drawing_q <= 1'b0;
                        active_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/multi_sprite_line_engine.sv
// Multi-sprite scanline engine: fetches next-line bitmaps at hsync, then draws with fixed priority.
// gfx/gfx_id one clk after hpos; ROM data used the clk after rom_addr; no backpressure (late fetch flags overrun).
module multi_sprite_line_engine
    import multi_sprite_line_engine_pkg::*;
#(
    parameter int NUM_SPRITES = 4,
    parameter int SPR_W       = 16,
    parameter int SPR_H       = 16,
    parameter int BMP_W       = 3,
    parameter int ROM_AW      = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [8:0]                   hpos,
    input  logic [8:0]                   vpos,
    input  logic                         hsync,
    input  logic                         vsync,
    input  logic [NUM_SPRITES-1:0]       spr_en,
    input  logic [8*NUM_SPRITES-1:0]     spr_x,
    input  logic [8*NUM_SPRITES-1:0]     spr_y,
    input  logic [BMP_W*NUM_SPRITES-1:0] spr_bmp,
    input  logic [NUM_SPRITES-1:0]       spr_hmir,
    input  logic [NUM_SPRITES-1:0]       spr_vmir,
    output logic [ROM_AW-1:0]            rom_addr,
    input  logic [7:0]                   rom_bits,
    output logic                         gfx,
    output logic [2:0]                   gfx_id,
    output logic [NUM_SPRITES-1:0]       collision,
    output logic                         overrun,
    output logic                         busy
);

    localparam int BYTES  = SPR_W / 8;
    localparam int BYTE_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int ROW_W  = $clog2(SPR_H);
    localparam int ADDR_W = BMP_W + ROW_W + BYTE_W;

    fetch_state_t     state_q, state_d;
    logic             hsync_q, vsync_q, hs_rise, vs_rise;
    logic [8:0]       line_q, row;
    logic [2:0]       slot_q;
    logic [BYTE_W-1:0] byte_q;
    logic [ROW_W-1:0] row_q, row_sel;
    logic [BMP_W-1:0] bmp_q;
    logic             vmir_q;
    logic             cur_en, cur_hmir, cur_vmir;
    logic [7:0]       cur_x, cur_y;
    logic [BMP_W-1:0] cur_bmp;
    logic             hit, last_slot, last_byte;
    logic             ld_hit, miss, fetch_wr, fetch_done;
    logic [ADDR_W-1:0] addr_full;
    logic [NUM_SPRITES-1:0] opaque;
    slot_vec_t        opaque_all;

    assign hs_rise = hsync && !hsync_q;
    assign vs_rise = vsync && !vsync_q;
    assign busy    = (state_q != ST_IDLE);

    always_comb begin
        cur_en   = 1'b0;
        cur_hmir = 1'b0;
        cur_vmir = 1'b0;
        cur_x    = '0;
        cur_y    = '0;
        cur_bmp  = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            if (slot_q == 3'(i)) begin
                cur_en   = spr_en[i];
                cur_hmir = spr_hmir[i];
                cur_vmir = spr_vmir[i];
                cur_x    = spr_x[8*i +: 8];
                cur_y    = spr_y[8*i +: 8];
                cur_bmp  = spr_bmp[BMP_W*i +: BMP_W];
            end
        end
    end

    // 9-bit difference: sprites above the line wrap to large values and miss.
    assign row       = line_q - {1'b0, cur_y};
    assign hit       = cur_en && (row < 9'(SPR_H));
    assign last_slot = (slot_q == 3'(NUM_SPRITES - 1));
    assign last_byte = (byte_q == BYTE_W'(BYTES - 1));
    assign row_sel   = vmir_q ? ~row_q : row_q;
    assign addr_full = {bmp_q, row_sel, byte_q};

    always_comb begin
        state_d    = state_q;
        ld_hit     = 1'b0;
        miss       = 1'b0;
        fetch_wr   = 1'b0;
        fetch_done = 1'b0;
        case (state_q)
            ST_CHECK: begin
                if (hit) begin
                    ld_hit  = 1'b1;
                    state_d = ST_SETUP;
                end else begin
                    miss = 1'b1;
                    if (last_slot) state_d = ST_IDLE;
                end
            end
            ST_SETUP: state_d = ST_FETCH;
            ST_FETCH: begin
                fetch_wr = 1'b1;
                if (!last_byte) begin
                    state_d = ST_SETUP;
                end else begin
                    fetch_done = 1'b1;
                    state_d    = last_slot ? ST_IDLE : ST_CHECK;
                end
            end
            default: ;
        endcase
        if (hs_rise) begin
            state_d    = ST_CHECK;
            ld_hit     = 1'b0;
            miss       = 1'b0;
            fetch_wr   = 1'b0;
            fetch_done = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            line_q   <= '0;
            slot_q   <= '0;
            byte_q   <= '0;
            row_q    <= '0;
            bmp_q    <= '0;
            vmir_q   <= 1'b0;
            rom_addr <= '0;
            overrun  <= 1'b0;
        end else begin
            state_q <= state_d;
            hsync_q <= hsync;
            vsync_q <= vsync;
            if (hs_rise) begin
                line_q <= vpos + 9'd1;
                slot_q <= '0;
                byte_q <= '0;
                if (state_q != ST_IDLE) overrun <= 1'b1;
            end else begin
                if (ld_hit) begin
                    row_q  <= row[ROW_W-1:0];
                    bmp_q  <= cur_bmp;
                    vmir_q <= cur_vmir;
                    byte_q <= '0;
                end
                if (miss || fetch_done) slot_q <= slot_q + 3'd1;
                if (fetch_wr && !last_byte) byte_q <= byte_q + BYTE_W'(1);
                if (fetch_done) byte_q <= '0;
                if (state_q == ST_SETUP) rom_addr <= ROM_AW'(addr_full >> ((BYTES > 1) ? 0 : 1));
            end
        end
    end

    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_slot
        logic sel;
        assign sel = (slot_q == 3'(g));
        sprite_line_slot #(
            .SPR_W (SPR_W),
            .BYTE_W(BYTE_W)
        ) u_slot (
            .clk       (clk),
            .reset     (reset),
            .hpos      (hpos),
            .kill      (hs_rise),
            .load      (ld_hit && sel),
            .x_in      (cur_x),
            .hmir_in   (cur_hmir),
            .wr_en     (fetch_wr && sel),
            .wr_byte   (byte_q),
            .wr_dat    (rom_bits),
            .set_active(fetch_done && sel),
            .clr_active(miss && sel),
            .opaque    (opaque[g])
        );
    end

    assign opaque_all = slot_vec_t'(opaque);

    always_ff @(posedge clk) begin
        if (!reset) begin
            gfx       <= 1'b0;
            gfx_id    <= 3'd0;
            collision <= '0;
        end else begin
            gfx    <= |opaque;
            gfx_id <= lowest_set(opaque_all);
            if (vs_rise) collision <= '0;
            else if (multi_hot(opaque_all)) collision <= collision | opaque;
        end
    end

endmodule

// File: tb/tb_multi_sprite_line_engine.sv
// Bench for multi_sprite_line_engine: directed scanlines plus randomized lines against a pixel-level model.
module tb_multi_sprite_line_engine;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [8:0]     hpos, vpos;
    logic           hsync, vsync;
    logic [N-1:0]   spr_en, spr_hmir, spr_vmir;
    logic [8*N-1:0] spr_x, spr_y;
    logic [3*N-1:0] spr_bmp;
    logic [7:0]     rom_addr, rom_bits;
    logic           gfx;
    logic [2:0]     gfx_id;
    logic [N-1:0]   collision;
    logic           overrun, busy;

    logic [7:0] rom [256];
    assign rom_bits = rom[rom_addr];

    multi_sprite_line_engine dut (
        .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .hsync(hsync), .vsync(vsync),
        .spr_en(spr_en), .spr_x(spr_x), .spr_y(spr_y), .spr_bmp(spr_bmp),
        .spr_hmir(spr_hmir), .spr_vmir(spr_vmir), .rom_addr(rom_addr), .rom_bits(rom_bits),
        .gfx(gfx), .gfx_id(gfx_id), .collision(collision), .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    bit m_en[N], m_h[N], m_v[N];
    int m_x[N], m_y[N], m_bmp[N];
    logic [N-1:0] coll_exp;
    logic         ovr_exp;
    logic [7:0]   addr_exp;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int row_of(int i, int v);
        return (((v + 1) % 512) - m_y[i] + 512) % 512;
    endfunction

    function automatic bit hits(int i, int v);
        return m_en[i] && (row_of(i, v) < 16);
    endfunction

    function automatic int bm_row(int i, int v);
        return m_v[i] ? 15 - row_of(i, v) : row_of(i, v);
    endfunction

    function automatic bit pix_on(int i, int v, int h);
        int k, base;
        logic [15:0] w;
        k = h - m_x[i];
        if (!hits(i, v) || k < 0 || k > 15) return 1'b0;
        base = m_bmp[i] * 32 + bm_row(i, v) * 2;
        w = {rom[base + 1], rom[base]};
        return w[m_h[i] ? 15 - k : k];
    endfunction

    task automatic drive_attrs();
        for (int i = 0; i < N; i++) begin
            spr_en[i]          = m_en[i];
            spr_hmir[i]        = m_h[i];
            spr_vmir[i]        = m_v[i];
            spr_x[8*i +: 8]    = 8'(m_x[i]);
            spr_y[8*i +: 8]    = 8'(m_y[i]);
            spr_bmp[3*i +: 3]  = 3'(m_bmp[i]);
        end
    endtask

    task automatic set_slot(int i, bit en, int x, int y, int bmp, bit hm, bit vm);
        m_en[i] = en; m_x[i] = x; m_y[i] = y; m_bmp[i] = bmp; m_h[i] = hm; m_v[i] = vm;
    endtask

    task automatic clear_slots();
        for (int i = 0; i < N; i++) set_slot(i, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    endtask

    // Fetch for line v+1, then sweep hpos and compare every registered pixel.
    task automatic render_line(input int v, input int rst_at, input int vs_at);
        int n, nexp, id;
        bit killed;
        logic [N-1:0] ops;
        hsync = 1'b0; vpos = 9'(v); hpos = 9'd400;
        drive_attrs();
        tick();
        hsync = 1'b1;
        tick();
        hsync = 1'b0;
        nexp = 0;
        for (int i = 0; i < N; i++) begin
            if (hits(i, v)) begin
                nexp += 5;
                addr_exp = 8'(m_bmp[i] * 32 + bm_row(i, v) * 2 + 1);
            end else begin
                nexp += 1;
            end
        end
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            tick();
        end
        check("busy_cycles", n, nexp);
        check("rom_addr", rom_addr, addr_exp);
        killed = 1'b0;
        for (int h = 0; h < 280; h++) begin
            hpos = 9'(h);
            vsync = (h == vs_at);
            if (h == rst_at) reset = 1'b0;
            tick();
            reset = 1'b1;
            vsync = 1'b0;
            if (h == rst_at) begin
                killed = 1'b1; coll_exp = '0; ovr_exp = 1'b0; addr_exp = '0;
                check("rst_gfx", gfx, 0);
                check("rst_busy", busy, 0);
                check("rst_collision", collision, 0);
                check("rst_overrun", overrun, 0);
            end else begin
                ops = '0;
                for (int i = 0; i < N; i++) ops[i] = !killed && pix_on(i, v, h);
                id = 0;
                for (int i = N - 1; i >= 0; i--) if (ops[i]) id = i;
                if (h == vs_at) coll_exp = '0;
                else if ($countones(ops) >= 2) coll_exp = coll_exp | ops;
                check("gfx", gfx, (ops != 0));
                check("gfx_id", gfx_id, id);
            end
        end
        check("collision", collision, coll_exp);
        check("overrun", overrun, ovr_exp);
    endtask

    task automatic rand_line(output int v);
        int bx;
        v = $urandom_range(0, 511);
        bx = $urandom_range(0, 255);
        for (int i = 0; i < N; i++)
            set_slot(i, $urandom_range(0, 3) != 0, (bx + $urandom_range(0, 14)) & 255,
                     (v + 1 - $urandom_range(0, 20)) & 255, $urandom_range(0, 7),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int v;
        for (int a = 0; a < 256; a++) rom[a] = 8'($urandom);
        reset = 1'b0; hsync = 1'b0; vsync = 1'b0; hpos = '0; vpos = '0;
        clear_slots();
        drive_attrs();
        coll_exp = '0; ovr_exp = 1'b0; addr_exp = '0;
        repeat (3) tick();
        check("reset_gfx", gfx, 0);
        check("reset_gfx_id", gfx_id, 0);
        check("reset_collision", collision, 0);
        check("reset_overrun", overrun, 0);
        check("reset_busy", busy, 0);
        check("reset_rom_addr", rom_addr, 0);
        reset = 1'b1;
        tick();

        // Single sprite, pixels 0 and 15 only
        rom[0] = 8'h01; rom[1] = 8'h80;
        set_slot(0, 1'b1, 40, 20, 0, 1'b0, 1'b0);
        render_line(19, -1, -1);
        // Horizontal mirror, then vertical mirror (row field 15)
        rom[0] = 8'h03; rom[1] = 8'h00;
        set_slot(0, 1'b1, 40, 20, 0, 1'b1, 1'b0);
        render_line(19, -1, -1);
        rom[30] = 8'hA5; rom[31] = 8'h3C;
        set_slot(0, 1'b1, 40, 20, 0, 1'b1, 1'b1);
        render_line(19, -1, -1);
        check("vmir_row_field", rom_addr[4:1], 15);

        // Two overlapping slots: priority and sticky collision, cleared by vsync
        rom[32] = 8'hFF; rom[33] = 8'hFF; rom[64] = 8'h0F; rom[65] = 8'h0F;
        clear_slots();
        set_slot(0, 1'b1, 60, 10, 1, 1'b0, 1'b0);
        set_slot(2, 1'b1, 60, 10, 2, 1'b0, 1'b0);
        render_line(9, -1, -1);
        check("collision_pair", collision, 4'b0101);
        render_line(100, -1, -1);
        check("collision_held", collision, 4'b0101);
        vsync = 1'b1; tick(); vsync = 1'b0; tick();
        coll_exp = '0;
        check("collision_clear", collision, 0);

        // Overrun: second hsync edge 12 clks into a 20-clk fetch
        for (int i = 0; i < N; i++) set_slot(i, 1'b1, 30 + 20 * i, 20 + i, i, 1'b0, 1'b0);
        vpos = 9'd29; hpos = 9'd400; drive_attrs();
        hsync = 1'b0; tick(); hsync = 1'b1; tick(); hsync = 1'b0;
        repeat (10) tick();
        check("busy_mid_fetch", busy, 1);
        m_en[2] = 1'b0; m_en[3] = 1'b0; ovr_exp = 1'b1;
        render_line(29, -1, -1);

        // Line-number wrap cases and an all-disabled line
        clear_slots();
        set_slot(1, 1'b1, 100, 250, 3, 1'b0, 1'b0);
        render_line(254, -1, -1);
        set_slot(1, 1'b1, 100, 0, 5, 1'b0, 1'b1);
        render_line(511, -1, -1);
        clear_slots();
        render_line(60, -1, -1);

        // Re-arm a collision, then reset mid-draw of the single sprite
        set_slot(0, 1'b1, 60, 10, 1, 1'b0, 1'b0);
        set_slot(2, 1'b1, 60, 10, 2, 1'b0, 1'b0);
        render_line(9, -1, -1);
        rom[0] = 8'hFF; rom[1] = 8'hFF;
        clear_slots();
        set_slot(0, 1'b1, 40, 20, 0, 1'b0, 1'b0);
        render_line(19, 45, -1);
        render_line(19, -1, -1);

        // Randomized lines, some with a vsync edge landing mid-sweep
        for (int t = 0; t < 25; t++) begin
            rand_line(v);
            render_line(v, -1, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 279)) : -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
